// File: rtl/jtkiwi_shram_pkg.sv
// Shared types and constants for the Kiwi main/sub communication RAM arbiter.
package jtkiwi_shram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAIN = 2'd1,
        ST_SUB  = 2'd2
    } state_t;

    localparam logic       OWN_MAIN = 1'b0;
    localparam logic       OWN_SUB  = 1'b1;
    localparam logic [4:0] CNT_MAX  = 5'd31;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        logic [4:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + 5'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtkiwi_shram_port.sv
// One requester's side of the shared RAM: ready flag, read-data register and wait.
module jtkiwi_shram_port #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          grant,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] dout,
    output logic          stall
);

    logic rdy;

    // rdy rises one cycle into a grant so that RAM read latency is covered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy <= 1'b0;
        end else begin
            rdy <= grant & cs;
        end
    end

    // read data follows the RAM only while this port is ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (rdy) begin
            dout <= ram_dout;
        end else begin
            dout <= dout;
        end
    end

    assign stall = cs & ~(grant & rdy);

endmodule

// File: rtl/jtkiwi_shram_arb.sv
// Main/sub Z80 arbiter for the shared 8 kB RAM; grants are held until cs drops.
// Define JTKIWI_SHRAM_RR_EN for round-robin tie-break in IDLE (default: main wins).
module jtkiwi_shram_arb
    import jtkiwi_shram_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [DW-1:0] main_din,
    output logic [DW-1:0] main_dout,
    output logic          main_wait,
    input  logic          sub_cs,
    input  logic          sub_rnw,
    input  logic [AW-1:0] sub_addr,
    input  logic [DW-1:0] sub_din,
    output logic [DW-1:0] sub_dout,
    output logic          sub_wait,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic [7:0]    st_dout
);

    state_t        state, state_nxt, tie_state;
    logic          last;
    logic [4:0]    cnt;
    logic          grant_main, grant_sub, contended;
    logic [AW-1:0] ram_addr_s;
    logic [DW-1:0] ram_din_s;
    logic          ram_we_s;

`ifdef JTKIWI_SHRAM_RR_EN
    assign tie_state = (last == OWN_MAIN) ? ST_SUB : ST_MAIN;
`else
    assign tie_state = ST_MAIN;
`endif

    assign grant_main = (state == ST_MAIN);
    assign grant_sub  = (state == ST_SUB);
    assign contended  = main_cs & sub_cs & (state != ST_IDLE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: the owner keeps the RAM until its cs drops, then hands off directly
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (main_cs && sub_cs) begin
                    state_nxt = tie_state;
                end else if (main_cs) begin
                    state_nxt = ST_MAIN;
                end else if (sub_cs) begin
                    state_nxt = ST_SUB;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MAIN: begin
                if (main_cs) begin
                    state_nxt = ST_MAIN;
                end else if (sub_cs) begin
                    state_nxt = ST_SUB;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SUB: begin
                if (sub_cs) begin
                    state_nxt = ST_SUB;
                end else if (main_cs) begin
                    state_nxt = ST_MAIN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // RAM port selection for the owner of the coming cycle
    always_comb begin
        ram_addr_s = main_addr;
        ram_din_s  = main_din;
        ram_we_s   = 1'b0;
        case (state_nxt)
            ST_MAIN: begin
                ram_addr_s = main_addr;
                ram_din_s  = main_din;
                ram_we_s   = ~main_rnw;
            end
            ST_SUB: begin
                ram_addr_s = sub_addr;
                ram_din_s  = sub_din;
                ram_we_s   = ~sub_rnw;
            end
            default: begin
                ram_addr_s = main_addr;
                ram_din_s  = main_din;
                ram_we_s   = 1'b0;
            end
        endcase
    end

    // registered RAM port; reset clears the strobe immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
        end else begin
            ram_addr <= ram_addr_s;
            ram_din  <= ram_din_s;
            ram_we   <= ram_we_s;
        end
    end

    // last grantee and saturating contention counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= OWN_SUB;
            cnt  <= 5'd0;
        end else begin
            if (state_nxt == ST_MAIN) begin
                last <= OWN_MAIN;
            end else if (state_nxt == ST_SUB) begin
                last <= OWN_SUB;
            end else begin
                last <= last;
            end
            if (contended) begin
                cnt <= sat_inc(cnt);
            end else begin
                cnt <= cnt;
            end
        end
    end

    assign st_dout = {state, last, cnt};

    jtkiwi_shram_port #(.DW(DW)) u_main (
        .clk      (clk),
        .rst      (rst),
        .cs       (main_cs),
        .grant    (grant_main),
        .ram_dout (ram_dout),
        .dout     (main_dout),
        .stall    (main_wait)
    );

    jtkiwi_shram_port #(.DW(DW)) u_sub (
        .clk      (clk),
        .rst      (rst),
        .cs       (sub_cs),
        .grant    (grant_sub),
        .ram_dout (ram_dout),
        .dout     (sub_dout),
        .stall    (sub_wait)
    );

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Scoreboard bench for jtkiwi_shram_arb: transaction-level RAM model plus a cycle-level grant model.
module tb_jtkiwi_shram_arb;
    import jtkiwi_shram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        main_cs = 1'b0, main_rnw = 1'b1, sub_cs = 1'b0, sub_rnw = 1'b1;
    logic [12:0] main_addr = 13'd0, sub_addr = 13'd0;
    logic [7:0]  main_din = 8'd0, sub_din = 8'd0;
    logic [7:0]  main_dout, sub_dout, ram_din, st_dout;
    logic        main_wait, sub_wait, ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_dout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtkiwi_shram_arb #(.AW(13), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr), .main_din(main_din),
        .main_dout(main_dout), .main_wait(main_wait),
        .sub_cs(sub_cs), .sub_rnw(sub_rnw), .sub_addr(sub_addr), .sub_din(sub_din),
        .sub_dout(sub_dout), .sub_wait(sub_wait),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .st_dout(st_dout)
    );

    // RAM instance model, with a preload port used during reset
    logic [7:0]  mem [0:8191];
    logic        pl_en = 1'b0;
    logic [12:0] pl_a = 13'd0;
    logic [7:0]  pl_d = 8'd0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // transaction-level reference memory and expected read data queues
    logic [7:0] ref_mem [0:8191];
    logic [7:0] mq[$];
    logic [7:0] sq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // grant model: 0 none, 1 main, 2 sub
    function automatic int next_owner(input int own, input bit mc, input bit sc, input bit lst);
        if (own == 1 && mc) return 1;
        if (own == 2 && sc) return 2;
        if (own == 1) return sc ? 2 : 0;
        if (own == 2) return mc ? 1 : 0;
        if (mc && sc) begin
`ifdef JTKIWI_SHRAM_RR_EN
            return lst ? 1 : 2;
`else
            return 1;
`endif
        end
        if (mc) return 1;
        if (sc) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] own_code(input int own);
        if (own == 1) return ST_MAIN;
        if (own == 2) return ST_SUB;
        return ST_IDLE;
    endfunction

    int       own_m = 0;
    int       age_m = 0;
    bit       last_m = 1'b1;
    int       cnt_m = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own_m  <= 0;
            age_m  <= 0;
            last_m <= 1'b1;
            cnt_m  <= 0;
        end else begin
            own_m  <= next_owner(own_m, main_cs, sub_cs, last_m);
            age_m  <= (next_owner(own_m, main_cs, sub_cs, last_m) == 0) ? 0 :
                      (next_owner(own_m, main_cs, sub_cs, last_m) == own_m) ? 2 : 1;
            last_m <= (next_owner(own_m, main_cs, sub_cs, last_m) == 1) ? 1'b0 :
                      (next_owner(own_m, main_cs, sub_cs, last_m) == 2) ? 1'b1 : last_m;
            cnt_m  <= (main_cs && sub_cs && own_m != 0) ? ((cnt_m >= 31) ? 31 : cnt_m + 1) : cnt_m;
        end
    end

    // per-cycle comparison of waits, status and RAM strobe against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("main_wait", main_wait, main_cs && !(own_m == 1 && age_m >= 2));
            check("sub_wait", sub_wait, sub_cs && !(own_m == 2 && age_m >= 2));
            check("st_dout", st_dout, {own_code(own_m), last_m, 5'(cnt_m)});
            check("ram_we", ram_we, (own_m == 1) ? !main_rnw : (own_m == 2) ? !sub_rnw : 1'b0);
            if (own_m != 0) check("ram_addr", ram_addr, (own_m == 1) ? main_addr : sub_addr);
            if (own_m == 1 && !main_rnw) check("ram_din", ram_din, main_din);
            if (own_m == 2 && !sub_rnw) check("ram_din", ram_din, sub_din);
        end
    end

    // scoreboard monitors: a read completes one cycle after its wait falls
    bit m_pend = 0, m_done = 0, s_pend = 0, s_done = 0;
    always @(negedge clk) begin
        if (rst) begin
            m_pend <= 0;
            m_done <= 0;
        end else begin
            if (m_pend) begin
                if (mq.size() == 0) check("main_sb_nonempty", mq.size() != 0, 1'b1);
                else check("main_rdata", main_dout, mq.pop_front());
            end
            m_pend <= main_cs && main_rnw && !main_wait && !m_done;
            m_done <= main_cs && (m_done || (main_rnw && !main_wait));
        end
    end
    always @(negedge clk) begin
        if (rst) begin
            s_pend <= 0;
            s_done <= 0;
        end else begin
            if (s_pend) begin
                if (sq.size() == 0) check("sub_sb_nonempty", sq.size() != 0, 1'b1);
                else check("sub_rdata", sub_dout, sq.pop_front());
            end
            s_pend <= sub_cs && sub_rnw && !sub_wait && !s_done;
            s_done <= sub_cs && (s_done || (sub_rnw && !sub_wait));
        end
    end

    // one CPU access: request, wait for the stall to clear, hold, release
    task automatic access(input int p, input bit rnw, input logic [12:0] a,
                          input logic [7:0] d, input int hold);
        int n;
        @(posedge clk); #1;
        if (rnw) begin
            if (p == 0) mq.push_back(ref_mem[a]);
            else sq.push_back(ref_mem[a]);
        end else begin
            ref_mem[a] = d;
        end
        if (p == 0) begin
            main_cs = 1'b1; main_rnw = rnw; main_addr = a; main_din = d;
        end else begin
            sub_cs = 1'b1; sub_rnw = rnw; sub_addr = a; sub_din = d;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((p == 0) ? main_wait : sub_wait) && n < 200);
        if (n >= 200) check((p == 0) ? "main_wait_timeout" : "sub_wait_timeout",
                            (p == 0) ? main_wait : sub_wait, 1'b0);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        if (p == 0) main_cs = 1'b0;
        else sub_cs = 1'b0;
    endtask

    // both ports request in the same cycle; the expected winner is checked explicitly
    task automatic collide(input bit exp_main_first, input int hold);
        fork
            access(0, 1'b1, 13'h0040, 8'h00, hold);
            access(1, 1'b1, 13'h1040, 8'h00, hold);
            begin
                @(posedge clk); #1;
                repeat (3) @(negedge clk);
                check("tie_main_wait", main_wait, !exp_main_first);
                check("tie_sub_wait", sub_wait, exp_main_first);
            end
        join
    endtask

    logic [7:0] old_byte;

    initial begin
        pl_en = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            pl_a = 13'(i);
            pl_d = 8'($urandom);
            ref_mem[i] = pl_d;
            @(posedge clk); #1;
        end
        pl_a = 13'h0123; pl_d = 8'h5A; ref_mem[13'h0123] = 8'h5A;
        @(posedge clk); #1;
        pl_en = 1'b0;

        check("rst_st_dout", st_dout, 8'h20);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 13'h0000);
        check("rst_ram_din", ram_din, 8'h00);
        check("rst_main_dout", main_dout, 8'h00);
        check("rst_sub_dout", sub_dout, 8'h00);
        main_cs = 1'b1; #1;
        check("rst_main_wait_cs", main_wait, 1'b1);
        main_cs = 1'b0; #1;
        check("rst_main_wait_idle", main_wait, 1'b0);
        @(negedge clk); #2 rst = 1'b0;

        access(0, 1'b1, 13'h0123, 8'h00, 0);
        access(1, 1'b0, 13'h1FFF, 8'hA5, 1);
        access(0, 1'b1, 13'h1FFF, 8'h00, 0);

        collide(1'b1, 3);
        collide(1'b1, 2);
        access(0, 1'b1, 13'h0200, 8'h00, 0);
`ifdef JTKIWI_SHRAM_RR_EN
        collide(1'b0, 2);
`else
        collide(1'b1, 2);
`endif

        fork
            access(0, 1'b1, 13'h0300, 8'h00, 45);
            begin
                repeat (2) @(posedge clk);
                access(1, 1'b1, 13'h1300, 8'h00, 0);
            end
        join
        check("cnt_saturated", st_dout[4:0], 5'd31);

        fork
            for (int i = 0; i < 40; i++) begin
                access(0, 1'($urandom), {1'b0, 12'($urandom)}, 8'($urandom), $urandom_range(0, 3));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            for (int j = 0; j < 40; j++) begin
                access(1, 1'($urandom), {1'b1, 12'($urandom)}, 8'($urandom), $urandom_range(0, 3));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        join

        // sub write interrupted by reset must never reach the RAM
        @(posedge clk); #1;
        old_byte = mem[13'h1ABC];
        sub_cs = 1'b1; sub_rnw = 1'b0; sub_addr = 13'h1ABC; sub_din = ~old_byte;
        repeat (2) @(negedge clk);
        check("we_before_rst", ram_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_we", ram_we, 1'b0);
        check("rst_mid_st", st_dout, 8'h20);
        check("rst_mid_sub_wait", sub_wait, 1'b1);
        check("rst_mid_main_wait", main_wait, 1'b0);
        check("rst_mid_main_dout", main_dout, 8'h00);
        check("rst_mid_sub_dout", sub_dout, 8'h00);
        repeat (2) @(posedge clk);
        #1 sub_cs = 1'b0; sub_rnw = 1'b1;
        #1 check("rst_mid_sub_wait_low", sub_wait, 1'b0);
        check("rst_no_write", mem[13'h1ABC], old_byte);
        @(negedge clk); #2 rst = 1'b0;

        access(0, 1'b1, 13'h1ABC, 8'h00, 0);
        access(1, 1'b1, 13'h0123, 8'h00, 0);
        repeat (3) @(posedge clk);
        check("main_sb_drained", mq.size(), 0);
        check("sub_sb_drained", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtkiwi_shram_arb.md
# jtkiwi_shram_arb

Arbiter for the 8 kB main/sub communication RAM in the Kiwi core. It shares one single-port RAM between the main Z80 and the sub (sound) Z80. It grants the RAM to one CPU at a time and generates a wait signal for the CPU that is held off. Returned read data is registered per requester. It sits between the two CPU bus decoders and the RAM instance, replacing per-port enables with one arbitrated port.

## Interface
Parameters:
- AW, 13, RAM address width.
- DW, 8, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high.
- main_cs  in  1  main CPU RAM request. Already qualified with mreq/rfsh.
- main_rnw  in  1  main CPU read (1) / write (0).
- main_addr  in  AW  main CPU address.
- main_din  in  DW  main CPU write data.
- main_dout  out  DW  data returned to the main CPU.
- main_wait  out  1  stall request to the main CPU's wait logic.
- sub_cs, sub_rnw, sub_addr, sub_din, sub_dout, sub_wait: same as the main_* ports, for the sub CPU.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_dout  in  DW  RAM read data. Valid 1 clk after the address is presented.
- st_dout  out  8  debug status: {owner[1:0], last[0], cnt[4:0]}.

## Operation
- State machine states: IDLE, MAIN, SUB. Encoding is taken from the shared package.
- IDLE
  - Only main_cs set: go to MAIN.
  - Only sub_cs set: go to SUB.
  - Both set: the tie-break rule under Configuration decides.
- MAIN
  - Stay while main_cs=1.
  - When main_cs=0: go to SUB if sub_cs=1, else go to IDLE.
  - Hand-off to SUB takes no idle cycle.
- SUB: mirror of MAIN.
- A grant is never pre-empted. The owner holds the RAM until it drops its cs.
- Address and write-data mux:
  - ram_addr/ram_din come from the owner's address/data.
  - In IDLE they come from main; ram_we=0.
- Write strobe: ram_we = owner's ~rnw in every granted cycle. Repeated writes of stable data are harmless.
- rdy flag per port:
  - Set 1 cycle after grant entry.
  - Cleared when the port's cs=0 or its grant ends.
- Read data: while rdy=1, the port's dout register captures ram_dout every cycle. Otherwise dout holds its value.
- Wait: x_wait = x_cs & ~(grant_x & rdy_x). Purely combinational from registers and cs.
- Contention counter cnt (5 bits):
  - Increments, saturating at 31, on each cycle where both cs are set and exactly one is granted.
  - Never wraps.
- last: 0 if main was granted most recently, 1 if sub.

## Timing
- Reset values:
  - state IDLE, last=1, cnt=0, rdy=0.
  - main_dout=sub_dout=0.
  - ram_we=0, ram_addr=0, ram_din=0.
  - main_wait=main_cs, sub_wait=sub_cs (combinational).
- Uncontended request with cs rising in cycle n:
  - Grant registered at n+1.
  - RAM address driven at n+1.
  - rdy and wait=0 at n+2.
  - dout valid at n+2 (registered data at n+3 edge).
- Contended request: the waiting port is granted in the cycle after the owner's cs falls. Its wait falls 2 cycles after that.
- Simultaneous cs rise on both ports: exactly one grant. The loser's wait stays high throughout.
- Reset mid-access: the FSM returns to IDLE immediately. No write is issued after rst rises.

## Configuration
- JTKIWI_SHRAM_RR_EN defined: a tie in IDLE goes to the port that was not granted last (round-robin via last).
- Not defined: a tie in IDLE always goes to main (fixed priority). last is still tracked for st_dout.

## Structure
- Package jtkiwi_shram_pkg holds:
  - state enum (IDLE/MAIN/SUB).
  - owner constants OWN_MAIN=0, OWN_SUB=1.
  - CNT_MAX=31.
- One sub-module, jtkiwi_shram_port, instantiated twice. It contains the rdy flag, the dout register and the wait generation for one requester.
- The FSM, the muxes and the counter live in the top module.

## Test plan
- Main read alone: preload 0x0123=0x5A, main_cs=1, rnw=1 → main_wait high 2 cycles, then main_dout=0x5A; sub_wait=0 throughout.
- Sub write then main read: sub writes 0xA5 to 0x1FFF, releases; main reads 0x1FFF → 0xA5; ram_we only during sub grant.
- Collision: both cs rise same cycle from reset → main granted first (both configs, since last=1); sub_wait held until main_cs drops, sub granted next cycle with no IDLE gap; cnt increments per stalled cycle.
- Repeat collision after sub was last granted: with JTKIWI_SHRAM_RR_EN main granted; without it main granted; after a main-last collision, RR build grants sub, fixed build grants main.
- Saturation: hold contention 40 cycles → cnt=31, no wrap.
- Reset during sub write: assert rst while SUB with rnw=0 → ram_we=0 same cycle, state IDLE, waits follow cs, douts=0.
